// File: rtl/channel_ctrl.sv
// Per-channel front-end controller: sequences sample/CSA reset around each hit
// and buffers timestamped ADC words in a small first-word-fall-through FIFO.
module channel_ctrl #(
    parameter int ADCBITS        = 10,
    parameter int TS_BITS        = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       hit,
    input  logic                       done,
    input  logic [ADCBITS-1:0]         dout,
    input  logic [TS_BITS-1:0]         timestamp,
    input  logic                       channel_enabled,
    input  logic [7:0]                 sample_cycles,
    input  logic [7:0]                 reset_cycles,
    output logic                       sample,
    output logic                       csa_reset,
    input  logic                       fifo_rd,
    output logic [TS_BITS+ADCBITS-1:0] fifo_dout,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       fifo_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (TW > 8) ? TW : 8;
    localparam int WW = TS_BITS + ADCBITS;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        SAMPLE,
        CONVERT,
        STORE,
        CSA_RST,
        REARM
    } state_t;

    state_t state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [TS_BITS-1:0] ts_q;
    logic [ADCBITS-1:0] adc_q;
    logic               ts_load, adc_load, fifo_wr, set_ovf;
    logic               hit_meta, hit_s, done_meta, done_s;

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [WW-1:0] hold_q;
    logic          rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_meta  <= 1'b0;
            hit_s     <= 1'b0;
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            hit_meta  <= hit;
            hit_s     <= hit_meta;
            done_meta <= done;
            done_s    <= done_meta;
        end
    end

    // Disabling overrides every state; while disabled the reset count is held at its start.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ts_load    = 1'b0;
        adc_load   = 1'b0;
        fifo_wr    = 1'b0;
        set_ovf    = 1'b0;
        if (!channel_enabled) begin
            state_next = CSA_RST;
            cnt_next   = CW'(reset_cycles);
        end else begin
            case (state)
                IDLE: begin
                    if (hit_s) begin
                        state_next = HOLD;
                        cnt_next   = CW'(sample_cycles);
                        ts_load    = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state_next = SAMPLE;
                        cnt_next   = CW'(1);
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        state_next = CONVERT;
                        cnt_next   = CW'(TIMEOUT_CYCLES);
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
                CONVERT: begin
                    if (done_s) begin
                        state_next = STORE;
                        adc_load   = 1'b1;
                    end else if (cnt <= CW'(1)) begin
                        state_next = CSA_RST;
                        cnt_next   = CW'(reset_cycles);
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
                STORE: begin
                    if (!fifo_full || fifo_rd) begin
                        fifo_wr = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                    state_next = CSA_RST;
                    cnt_next   = CW'(reset_cycles);
                end
                CSA_RST: begin
                    if (cnt == '0) begin
                        state_next = REARM;
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
                REARM: begin
                    if (!hit_s && !done_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ts_q          <= '0;
            adc_q         <= '0;
            sample        <= 1'b0;
            csa_reset     <= 1'b1;
            fifo_overflow <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sample    <= (state_next == SAMPLE);
            csa_reset <= (state_next == CSA_RST);
            if (ts_load) begin
                ts_q <= timestamp;
            end
            if (adc_load) begin
                adc_q <= dout;
            end
            if (set_ovf) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

    assign rd_en      = fifo_rd && !fifo_empty;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_dout  = fifo_empty ? hold_q : mem[rd_ptr[AW-1:0]];

    // hold_q keeps the last popped word so the output stays put once the FIFO drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr[AW-1:0]] <= {ts_q, adc_q};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                hold_q <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_channel_ctrl.sv
// Self-checking bench for channel_ctrl: directed scenarios plus randomized events,
// compared against a queue-based model of the stored words and the overflow flag.
module tb_channel_ctrl;

    localparam int ADCBITS = 10;
    localparam int TS_BITS = 24;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;
    localparam int WW      = TS_BITS + ADCBITS;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               hit;
    logic               done;
    logic [ADCBITS-1:0] dout;
    logic [TS_BITS-1:0] timestamp;
    logic               channel_enabled;
    logic [7:0]         sample_cycles;
    logic [7:0]         reset_cycles;
    logic               sample;
    logic               csa_reset;
    logic               fifo_rd;
    logic [WW-1:0]      fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_overflow;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [WW-1:0] exp_q[$];
    bit            exp_ovf  = 1'b0;
    bit            hold_hit = 1'b0;

    channel_ctrl #(
        .ADCBITS(ADCBITS),
        .TS_BITS(TS_BITS),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hit(hit),
        .done(done),
        .dout(dout),
        .timestamp(timestamp),
        .channel_enabled(channel_enabled),
        .sample_cycles(sample_cycles),
        .reset_cycles(reset_cycles),
        .sample(sample),
        .csa_reset(csa_reset),
        .fifo_rd(fifo_rd),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // The timestamp advances just after every edge, acting as the free-running chip counter.
    task automatic tick();
        @(posedge clk);
        #1;
        timestamp = timestamp + 24'd1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFifo(input string tag);
        checkOutput({tag, "_empty"}, 64'(fifo_empty), 64'(exp_q.size() == 0));
        checkOutput({tag, "_full"}, 64'(fifo_full), 64'(exp_q.size() == DEPTH));
        checkOutput({tag, "_ovf"}, 64'(fifo_overflow), 64'(exp_ovf));
        if (exp_q.size() > 0) begin
            checkOutput({tag, "_head"}, 64'(fifo_dout), 64'(exp_q[0]));
        end
    endtask

    task automatic waitSample(input logic val, input int limit, output int n);
        n = 0;
        while (sample !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic waitCsa(input logic val, input int limit, output int n);
        n = 0;
        while (csa_reset !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    // One complete hit/convert/store/reset event; the model decides what the FIFO must hold.
    task automatic applyStimulus(input int sc, input int rc, input logic [ADCBITS-1:0] adc,
                                 input int done_dly, input bit rd_at_store);
        int            n;
        logic [WW-1:0] exp_word;
        bit            accept;
        sample_cycles = 8'(sc);
        reset_cycles  = 8'(rc);
        exp_word      = {timestamp + 24'd2, adc};
        hit           = 1'b1;
        waitSample(1'b1, 300, n);
        checkOutput("hit_to_sample", 64'(n), 64'(sc + 4));
        waitSample(1'b0, 10, n);
        checkOutput("sample_width", 64'(n), 64'(2));
        if (!hold_hit) hit = 1'b0;
        repeat (done_dly) tick();
        dout = adc;
        done = 1'b1;
        repeat (3) tick();
        checkOutput("csa_before_store", 64'(csa_reset), 64'(0));
        accept  = (exp_q.size() < DEPTH) || rd_at_store;
        fifo_rd = rd_at_store;
        if (rd_at_store && exp_q.size() > 0) begin
            checkOutput("head_at_store", 64'(fifo_dout), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        tick();
        fifo_rd = 1'b0;
        checkOutput("csa_after_store", 64'(csa_reset), 64'(1));
        if (accept) exp_q.push_back(exp_word);
        else exp_ovf = 1'b1;
        done = 1'b0;
        dout = ADCBITS'($urandom);
        waitCsa(1'b0, 300, n);
        checkOutput("csa_width", 64'(n), 64'(rc + 1));
        checkFifo("event");
        if (!hold_hit) repeat (3) tick();
    endtask

    task automatic drainFifo();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            checkOutput("drain_head", 64'(fifo_dout), 64'(exp_q.pop_front()));
            fifo_rd = 1'b1;
            tick();
            fifo_rd = 1'b0;
            guard++;
        end
        checkOutput("drain_empty", 64'(fifo_empty), 64'(1));
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        checkOutput("rd_when_empty_empty", 64'(fifo_empty), 64'(1));
        checkOutput("rd_when_empty_full", 64'(fifo_full), 64'(0));
    endtask

    initial begin
        int n;
        int bad;
        reset_n         = 1'b0;
        hit             = 1'b0;
        done            = 1'b0;
        dout            = '0;
        timestamp       = TS_BITS'($urandom);
        channel_enabled = 1'b1;
        fifo_rd         = 1'b0;
        sample_cycles   = 8'd0;
        reset_cycles    = 8'd0;

        #12;
        checkOutput("rst_sample", 64'(sample), 64'(0));
        checkOutput("rst_csa", 64'(csa_reset), 64'(1));
        checkOutput("rst_dout", 64'(fifo_dout), 64'(0));
        checkFifo("rst");
        reset_n = 1'b1;
        repeat (2) tick();
        checkOutput("idle_csa", 64'(csa_reset), 64'(0));

        $display("[TB] basic event");
        timestamp = 24'h0000FE;
        applyStimulus(3, 4, 10'h2A5, 2, 1'b0);
        checkOutput("basic_word", 64'(fifo_dout), 64'({24'h000100, 10'h2A5}));
        drainFifo();

        $display("[TB] timeout");
        sample_cycles = 8'd2;
        reset_cycles  = 8'd3;
        hit = 1'b1;
        waitSample(1'b1, 300, n);
        checkOutput("to_hit_to_sample", 64'(n), 64'(6));
        waitSample(1'b0, 10, n);
        hit = 1'b0;
        waitCsa(1'b1, 400, n);
        checkOutput("to_wait", 64'(n), 64'(TIMEOUT));
        waitCsa(1'b0, 50, n);
        checkOutput("to_csa_width", 64'(n), 64'(4));
        repeat (3) tick();
        checkFifo("to");

        $display("[TB] stale hit");
        hold_hit = 1'b1;
        applyStimulus(1, 2, 10'h155, 1, 1'b0);
        bad = 0;
        repeat (20) begin
            tick();
            if (sample !== 1'b0) bad++;
        end
        checkOutput("stale_no_sample", 64'(bad), 64'(0));
        hold_hit = 1'b0;
        hit = 1'b0;
        repeat (4) tick();
        applyStimulus(2, 1, 10'h0F3, 0, 1'b0);

        $display("[TB] disable mid-conversion");
        sample_cycles = 8'd1;
        reset_cycles  = 8'd2;
        hit = 1'b1;
        waitSample(1'b1, 300, n);
        waitSample(1'b0, 10, n);
        hit = 1'b0;
        repeat (5) tick();
        dout = 10'h3C3;
        done = 1'b1;
        channel_enabled = 1'b0;
        tick();
        checkOutput("dis_csa_next", 64'(csa_reset), 64'(1));
        bad = 0;
        repeat (20) begin
            tick();
            if (csa_reset !== 1'b1) bad++;
        end
        checkOutput("dis_csa_held", 64'(bad), 64'(0));
        checkFifo("dis_nowrite");
        done = 1'b0;
        channel_enabled = 1'b1;
        waitCsa(1'b0, 20, n);
        checkOutput("dis_reenable", 64'(n >= 1 && n <= 3), 64'(1));
        repeat (4) tick();
        checkFifo("dis_after");
        drainFifo();

        $display("[TB] random events");
        for (int i = 0; i < 6; i++) begin
            timestamp = TS_BITS'($urandom);
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                          ADCBITS'($urandom), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
                checkOutput("rand_pop", 64'(fifo_dout), 64'(exp_q.pop_front()));
                fifo_rd = 1'b1;
                tick();
                fifo_rd = 1'b0;
            end
        end
        drainFifo();

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) begin
            timestamp = TS_BITS'($urandom);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ADCBITS'($urandom), int'($urandom_range(0, 5)), 1'b0);
        end
        checkOutput("ovf_full", 64'(fifo_full), 64'(1));
        checkOutput("ovf_flag", 64'(fifo_overflow), 64'(1));
        timestamp = TS_BITS'($urandom);
        applyStimulus(2, 2, ADCBITS'($urandom), 3, 1'b1);
        checkOutput("ovf_rd_full", 64'(fifo_full), 64'(1));
        drainFifo();
        applyStimulus(1, 1, ADCBITS'($urandom), 2, 1'b0);
        applyStimulus(0, 0, ADCBITS'($urandom), 0, 1'b0);

        $display("[TB] async reset during hold");
        sample_cycles = 8'd20;
        hit = 1'b1;
        repeat (6) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_sample", 64'(sample), 64'(0));
        checkOutput("ar_csa", 64'(csa_reset), 64'(1));
        checkOutput("ar_dout", 64'(fifo_dout), 64'(0));
        exp_q.delete();
        exp_ovf = 1'b0;
        checkFifo("ar");
        hit = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("ar_idle_csa", 64'(csa_reset), 64'(0));
        applyStimulus(4, 2, 10'h1E7, 4, 1'b0);
        drainFifo();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_ctrl.md
# channel_ctrl

Digital per-channel controller directly downstream of the analog channel model. It consumes the discriminator `hit`, the ADC `done` and `dout`, and drives `sample` and `csa_reset` back to the analog channel. Each conversion is stored as a timestamped word in a local first-word-fall-through FIFO for the chip-level readout arbiter.

## Interface
- `ADCBITS`, 10, ADC word width.
- `TS_BITS`, 24, timestamp width.
- `FIFO_DEPTH`, 4, local FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT_CYCLES`, 255, maximum number of cycles to wait for `done` before aborting.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `hit` in 1: discriminator output; asynchronous to `clk`.
- `done` in 1: ADC conversion finished; asynchronous to `clk`.
- `dout` in `ADCBITS`: ADC result, valid while `done` is high.
- `timestamp` in `TS_BITS`: free-running chip timestamp.
- `channel_enabled` in 1: config bit; 0 holds the channel disarmed.
- `sample_cycles` in 8: hold delay from hit to sample.
- `reset_cycles` in 8: CSA reset length minus 1.
- `sample` out 1: ADC sample strobe.
- `csa_reset` out 1: CSA reset / disarm.
- `fifo_rd` in 1: pop the head entry.
- `fifo_dout` out `TS_BITS+ADCBITS`: head entry `{ts, adc}`.
- `fifo_empty` out 1: FIFO holds no entries.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_overflow` out 1: sticky flag, set when a conversion is dropped; cleared only by `reset_n`.

## Operation
- `hit` and `done` each pass through a 2-flop synchronizer, giving `hit_s` and `done_s`. `dout` is sampled only when `done_s` = 1.
- State machine states: IDLE, HOLD, SAMPLE, CONVERT, STORE, CSA_RST, REARM.
  - IDLE: `csa_reset`=0. When `hit_s`=1 and `channel_enabled`=1, latch `timestamp` into `ts_q`, load the counter with `sample_cycles`, go to HOLD.
  - HOLD: decrement the counter. When the counter is 0, go to SAMPLE. `sample_cycles`=0 therefore gives one HOLD cycle.
  - SAMPLE: `sample`=1 for exactly 2 cycles, then go to CONVERT with the counter loaded to `TIMEOUT_CYCLES`.
  - CONVERT: when `done_s`=1, latch `dout` into `adc_q` and go to STORE. Otherwise decrement the counter; if the counter reaches 0, go to CSA_RST with no write.
  - STORE: lasts one cycle. If the FIFO is not full, or `fifo_rd` is asserted in the same cycle, write `{ts_q, adc_q}`. Otherwise drop the word and set `fifo_overflow`. Go to CSA_RST.
  - CSA_RST: `csa_reset`=1 for `reset_cycles`+1 cycles, then go to REARM.
  - REARM: `csa_reset`=0. Wait until `hit_s`=0 and `done_s`=0, then go to IDLE. This prevents retriggering on a stale hit.
- Disable: `channel_enabled`=0 in any state other than CSA_RST forces CSA_RST on the next cycle, with no FIFO write. While disabled, the controller stays in CSA_RST and `csa_reset` is held at 1. Re-enabling completes the normal CSA_RST count.
- FIFO: `fifo_dout` always shows the head entry, and its value is held when the FIFO is empty.
  - `fifo_rd` while empty is ignored.
  - Simultaneous read and write when full: both happen and the FIFO stays full.
  - Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap naturally.

## Timing
- Reset values:
  - state = IDLE
  - `sample`=0
  - `csa_reset`=1 while `reset_n`=0, then 0 in IDLE
  - `fifo_empty`=1, `fifo_full`=0, `fifo_overflow`=0, `fifo_dout`=0
  - synchronizers = 0
- All outputs are registered except `fifo_dout`, `fifo_empty` and `fifo_full`, which decode the FIFO registers.
- `hit` rising edge to HOLD entry: 3 cycles (2 synchronizer cycles plus the IDLE decision). `ts_q` is the `timestamp` value at the IDLE decision edge.
- `sample` rises `sample_cycles`+1 cycles after HOLD entry.
- `done` rising edge to STORE: 3 cycles. The FIFO entry is visible (`fifo_empty`=0) the cycle after STORE.
- `fifo_rd` takes effect at the clock edge. `fifo_dout` advances in the following cycle.
- Asserting `reset_n` mid-operation clears the FIFO and flags immediately and asynchronously; no partial write occurs.

## Test plan
- Basic event: `sample_cycles`=3, `reset_cycles`=4, `timestamp`=0x000100 at the IDLE decision, `done` with `dout`=0x2A5.
  - FIFO gets `{0x000100, 0x2A5}`.
  - `sample` is high for 2 cycles.
  - `csa_reset` is high for 5 cycles.
- Timeout: `hit`, never `done` → after `TIMEOUT_CYCLES`, `csa_reset` pulses, FIFO stays empty, `fifo_overflow`=0.
- Overflow: 5 events with no reads → `fifo_full`=1, the first 4 words are retained in order, `fifo_overflow`=1. A 5th event written with a simultaneous `fifo_rd` is accepted.
- Stale hit: `hit` held high through CSA_RST → stays in REARM, no second `sample` until `hit` falls and rises again.
- Disable mid-conversion: `channel_enabled`→0 during CONVERT → CSA_RST next cycle, no write, `csa_reset` held at 1 until re-enabled.
- Async reset during HOLD: `reset_n` pulse → outputs at their reset values immediately; the next `hit` produces a normal event.
